read_b_in_nbank: RTL and testbench
==================================

# read_b_in_nbank

Parametrised successor to the two-bank input reader. It drains NUM_BANKS interleaved input BRAM banks in strict round-robin order and presents one word per pop to user logic. Each word it consumes is invalidated by clearing its valid bit. It also returns credits to the upstream leaf interface: a full credit block, or a partial block after an idle timeout. It sits between the leaf-interface input BRAM banks and the user operator's input stream.

## Interface
- NUM_BANKS, 2: number of interleaved banks; a power of 2, at least 2.
- PAYLOAD_BITS, 64: payload width; each BRAM word is PAYLOAD_BITS+1 bits, with the valid flag in the MSB.
- NUM_ADDR_BITS, 7: total buffer address bits; per-bank address width BA = NUM_ADDR_BITS − log2(NUM_BANKS).
- FREESPACE_UPDATE_SIZE, 64: number of words per full credit block; at least 1.
- IDLE_TIMEOUT, 256: number of idle cycles before a partial credit flush; at least 2.
- clk, input, 1: clock.
- reset_n, input, 1: asynchronous, active-low reset.
- clear, input, 1: synchronous soft clear, active high.
- ap_start, input, 1: run enable.
- ack_user2b_in, input, 1: user accepts the presented word.
- doutb_flat, input, NUM_BANKS*(PAYLOAD_BITS+1): bank read data; bank k occupies slice k.
- addrb_flat, output, NUM_BANKS*BA: per-bank read/invalidate address, registered.
- web, output, NUM_BANKS: per-bank invalidate strobe, combinational.
- dout_leaf_interface2user, output, PAYLOAD_BITS: payload of the current bank.
- vld_bram_in2user, output, 1: the current word is valid and ap_start is high.
- freespace_update, output, 1: credit pulse, one cycle wide, registered.
- freespace_cnt, output, clog2(FREESPACE_UPDATE_SIZE+1): number of credits carried by the pulse; 0 when there is no pulse.

## Operation
- bank_ptr (log2(NUM_BANKS) bits) is the state: the bank currently presented; it resets to 0.
- Data path:
  - dout_leaf_interface2user is the payload slice of bank bank_ptr.
  - vld_bram_in2user is the valid bit of bank bank_ptr ANDed with ap_start.
- pop = vld_bram_in2user && ack_user2b_in. On pop:
  - web[bank_ptr]=1 in the same cycle, invalidating addrb of that bank; all other web bits are 0.
  - addrb of bank bank_ptr increments, wrapping mod 2^BA; other bank addresses hold.
  - bank_ptr increments, wrapping from NUM_BANKS−1 to 0.
  - consumed increments.
- ack_user2b_in without valid data is ignored: no pointer or address move, no web.
- Full credit block: a pop with consumed == FREESPACE_UPDATE_SIZE−1 gives
  - freespace_update=1 and freespace_cnt=FREESPACE_UPDATE_SIZE on the next cycle;
  - consumed reset to 0.
- Idle flush (only with the macro defined, see Configuration):
  - idle_cnt counts cycles with no pop while consumed>0.
  - When idle_cnt reaches IDLE_TIMEOUT−1 with no pop in that cycle, the next cycle gives freespace_update=1 and freespace_cnt=consumed. consumed and idle_cnt are cleared.
  - A pop clears idle_cnt.
  - A pop in the timeout cycle takes priority: no flush happens, and a full-block pulse is issued if one is due.
- clear:
  - Next cycle: bank_ptr, all addresses, consumed and idle_cnt are 0.
  - No credit pulse is issued; web is forced to 0 in the clear cycle.
  - clear overrides a pop issued in the same cycle.
- ap_start low: no pops and no web, and the valid output is 0. Counters hold; idle_cnt still advances.

## Timing
- Read path: the BRAM ports are treated as combinational for this block. The data/valid mux is zero-latency from doutb_flat; upstream supplies data for the registered addrb.
- At most one pop per cycle. Sustained throughput is 1 word/cycle while data is valid and ack is held high.
- Credit pulse is issued 1 cycle after the causing pop or timeout; back-to-back full blocks are possible.
- Reset values: addrb_flat=0, freespace_update=0, freespace_cnt=0, bank_ptr=0. web, valid and dout follow the inputs combinationally from this state.
- An asynchronous reset mid-stream discards the partial credit count.

## Configuration
- READ_B_IN_IDLE_FLUSH_EN defined:
  - idle_cnt and the partial flush are compiled in.
- Not defined:
  - Credits are returned only in full blocks of FREESPACE_UPDATE_SIZE.
  - idle_cnt logic is absent, and freespace_cnt is FREESPACE_UPDATE_SIZE whenever freespace_update=1.

## Structure
- Package read_b_in_pkg holds:
  - the clog2 helper function;
  - localparam derivations for BA, bank_ptr width and freespace_cnt width;
  - bank slice index functions for the flattened buses.
- Sub-module freespace_credit_ctr contains consumed, idle_cnt, the flush logic and the freespace_update/freespace_cnt registers. Its inputs are pop and clear.
- Top level contains bank_ptr, the address registers, the web decode and the data mux.

## Test plan
- NUM_BANKS=4, all banks valid, ack and ap_start held high for 8 cycles:
  - web sequence is 0001, 0010, 0100, 1000, repeated;
  - each addrb ends at 2;
  - bank_ptr ends at 0.
- Bank 2 invalid while bank_ptr=2, ack high: no pop, web=0, addresses hold. Once valid is restored, the pop proceeds.
- FREESPACE_UPDATE_SIZE=4, 8 pops: two pulses, each with freespace_cnt=4, one cycle after pops 4 and 8.
- Macro defined, IDLE_TIMEOUT=16:
  - 3 pops then idle: a pulse with freespace_cnt=3 exactly 16 cycles after the last pop, then no further pulses.
  - Pop in the timeout cycle: no flush.
- BA=3 on one bank, 8 pops there: its address wraps 7→0.
- clear and reset:
  - clear asserted together with a pop: no web, all pointers 0 next cycle, no pulse.
  - reset_n pulsed mid-stream: outputs return to reset values immediately.

Source files
------------

// File: rtl/read_b_in_pkg.sv
// read_b_in_pkg: shared helpers for the N-bank input reader.
// Width derivations, default parameter values and flattened-bus slice
// helpers used by read_b_in_nbank and freespace_credit_ctr.
// Optional feature macro (consumed by the other files): READ_B_IN_IDLE_FLUSH_EN.
package read_b_in_pkg;

  // Default configuration of the reader.
  localparam int DEFAULT_NUM_BANKS             = 2;
  localparam int DEFAULT_PAYLOAD_BITS          = 64;
  localparam int DEFAULT_NUM_ADDR_BITS         = 7;
  localparam int DEFAULT_FREESPACE_UPDATE_SIZE = 64;
  localparam int DEFAULT_IDLE_TIMEOUT          = 256;

  // Smallest r with 2**r >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Per-bank address width: the buffer address space is split evenly.
  function automatic int bank_addr_width(input int num_addr_bits, input int num_banks);
    return num_addr_bits - clog2(num_banks);
  endfunction

  // Width of the round-robin bank pointer.
  function automatic int bank_ptr_width(input int num_banks);
    return (num_banks > 1) ? clog2(num_banks) : 1;
  endfunction

  // Width able to hold a full credit block count.
  function automatic int credit_cnt_width(input int freespace_update_size);
    return clog2(freespace_update_size + 1);
  endfunction

  // Width of the idle cycle counter (counts 0 .. timeout-1).
  function automatic int idle_cnt_width(input int idle_timeout);
    return (idle_timeout > 1) ? clog2(idle_timeout) : 1;
  endfunction

  // LSB of bank k's word inside the flattened read-data bus.
  function automatic int word_lsb(input int bank, input int payload_bits);
    return bank * (payload_bits + 1);
  endfunction

  // LSB of bank k's address inside the flattened address bus.
  function automatic int addr_lsb(input int bank, input int bank_addr_bits);
    return bank * bank_addr_bits;
  endfunction

endpackage

// File: rtl/freespace_credit_ctr.sv
// freespace_credit_ctr: counts consumed words and returns credits upstream.
// Emits a one-cycle registered pulse carrying FREESPACE_UPDATE_SIZE credits
// after each full block. With READ_B_IN_IDLE_FLUSH_EN defined, a partial
// block is also flushed after IDLE_TIMEOUT idle cycles.
module freespace_credit_ctr
  import read_b_in_pkg::*;
#(
`ifdef READ_B_IN_IDLE_FLUSH_EN
  parameter int IDLE_TIMEOUT          = DEFAULT_IDLE_TIMEOUT,
`endif
  parameter int FREESPACE_UPDATE_SIZE = DEFAULT_FREESPACE_UPDATE_SIZE,
  localparam int CNT_W                = credit_cnt_width(FREESPACE_UPDATE_SIZE)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_pop,
  input  logic             i_clear,
  output logic             o_freespace_update,
  output logic [CNT_W-1:0] o_freespace_cnt
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FREESPACE_UPDATE_SIZE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FREESPACE_UPDATE_SIZE - 1);

  logic [CNT_W-1:0] r_consumed;
  logic             r_freespace_update;
  logic [CNT_W-1:0] r_freespace_cnt;
  logic             w_block_done;

  assign w_block_done       = i_pop && (r_consumed == LAST_CNT);
  assign o_freespace_update = r_freespace_update;
  assign o_freespace_cnt    = r_freespace_cnt;

`ifdef READ_B_IN_IDLE_FLUSH_EN
  localparam int IDLE_W = idle_cnt_width(IDLE_TIMEOUT);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);

  logic [IDLE_W-1:0] r_idle_cnt;
  logic              w_timeout;

  // A pop in the timeout cycle wins, so the flush requires no pop.
  assign w_timeout = !i_pop && (r_consumed != '0) && (r_idle_cnt == IDLE_LAST);

  // Count idle cycles only while a partial block is outstanding.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idle_cnt <= '0;
    end else if (i_clear || i_pop || (r_consumed == '0) || w_timeout) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end
`endif

  // Track consumed words and register the credit pulse and its count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_consumed         <= '0;
      r_freespace_update <= 1'b0;
      r_freespace_cnt    <= '0;
    end else if (i_clear) begin
      r_consumed         <= '0;
      r_freespace_update <= 1'b0;
      r_freespace_cnt    <= '0;
    end else begin
      r_freespace_update <= 1'b0;
      r_freespace_cnt    <= '0;
      if (i_pop) begin
        if (w_block_done) begin
          r_consumed         <= '0;
          r_freespace_update <= 1'b1;
          r_freespace_cnt    <= FULL_CNT;
        end else begin
          r_consumed <= r_consumed + 1'b1;
        end
      end
`ifdef READ_B_IN_IDLE_FLUSH_EN
      else if (w_timeout) begin
        r_consumed         <= '0;
        r_freespace_update <= 1'b1;
        r_freespace_cnt    <= r_consumed;
      end
`endif
    end
  end

endmodule

// File: rtl/read_b_in_nbank.sv
// read_b_in_nbank: drains NUM_BANKS interleaved input BRAM banks in strict
// round-robin order, presenting one word per pop to the user stream and
// invalidating each consumed word through web. Credits are returned by
// freespace_credit_ctr. Optional idle flush: READ_B_IN_IDLE_FLUSH_EN.
module read_b_in_nbank
  import read_b_in_pkg::*;
#(
  parameter int NUM_BANKS             = DEFAULT_NUM_BANKS,
  parameter int PAYLOAD_BITS          = DEFAULT_PAYLOAD_BITS,
  parameter int NUM_ADDR_BITS         = DEFAULT_NUM_ADDR_BITS,
  parameter int FREESPACE_UPDATE_SIZE = DEFAULT_FREESPACE_UPDATE_SIZE,
  parameter int IDLE_TIMEOUT          = DEFAULT_IDLE_TIMEOUT,
  localparam int BA                   = bank_addr_width(NUM_ADDR_BITS, NUM_BANKS),
  localparam int PTR_W                = bank_ptr_width(NUM_BANKS),
  localparam int CNT_W                = credit_cnt_width(FREESPACE_UPDATE_SIZE),
  localparam int WORD_W               = PAYLOAD_BITS + 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        clear,
  input  logic                        ap_start,
  input  logic                        ack_user2b_in,
  input  logic [NUM_BANKS*WORD_W-1:0] doutb_flat,
  output logic [NUM_BANKS*BA-1:0]     addrb_flat,
  output logic [NUM_BANKS-1:0]        web,
  output logic [PAYLOAD_BITS-1:0]     dout_leaf_interface2user,
  output logic                        vld_bram_in2user,
  output logic                        freespace_update,
  output logic [CNT_W-1:0]            freespace_cnt
);

  // Reject configurations the round-robin scheme cannot support.
  if ((NUM_BANKS < 2) || ((1 << clog2(NUM_BANKS)) != NUM_BANKS)) begin : g_bad_banks
    $error("read_b_in_nbank: NUM_BANKS must be a power of 2, at least 2");
  end
  if ((FREESPACE_UPDATE_SIZE < 1) || (IDLE_TIMEOUT < 2) || (BA < 1)) begin : g_bad_cfg
    $error("read_b_in_nbank: illegal credit, timeout or address configuration");
  end

  logic [PTR_W-1:0]  r_bank_ptr;
  logic [BA-1:0]     r_addr [NUM_BANKS];
  logic [WORD_W-1:0] w_word;
  logic              w_pop;

  // Select the BRAM word of the bank currently being presented.
  always_comb begin
    w_word = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (r_bank_ptr == PTR_W'(k)) begin
        w_word = doutb_flat[word_lsb(k, PAYLOAD_BITS) +: WORD_W];
      end
    end
  end

  assign dout_leaf_interface2user = w_word[PAYLOAD_BITS-1:0];
  assign vld_bram_in2user         = w_word[PAYLOAD_BITS] & ap_start;
  assign w_pop                    = vld_bram_in2user & ack_user2b_in;

  // Invalidate the consumed word; clear suppresses the write.
  always_comb begin
    web = '0;
    if (w_pop && !clear) begin
      web[r_bank_ptr] = 1'b1;
    end
  end

  // Advance the round-robin bank pointer on every pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bank_ptr <= '0;
    end else if (clear) begin
      r_bank_ptr <= '0;
    end else if (w_pop) begin
      r_bank_ptr <= r_bank_ptr + 1'b1;
    end
  end

  // Step the popped bank's read address, wrapping within the bank.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_BANKS; k++) r_addr[k] <= '0;
    end else if (clear) begin
      for (int k = 0; k < NUM_BANKS; k++) r_addr[k] <= '0;
    end else if (w_pop) begin
      r_addr[r_bank_ptr] <= r_addr[r_bank_ptr] + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_addr_flat
    assign addrb_flat[addr_lsb(g, BA) +: BA] = r_addr[g];
  end

  freespace_credit_ctr #(
`ifdef READ_B_IN_IDLE_FLUSH_EN
    .IDLE_TIMEOUT         (IDLE_TIMEOUT),
`endif
    .FREESPACE_UPDATE_SIZE(FREESPACE_UPDATE_SIZE)
  ) u_credit (
    .clk               (clk),
    .reset_n           (reset_n),
    .i_pop             (w_pop),
    .i_clear           (clear),
    .o_freespace_update(freespace_update),
    .o_freespace_cnt   (freespace_cnt)
  );

endmodule

// File: tb/tb_read_b_in_nbank.sv
// tb_read_b_in_nbank: self-checking bench for read_b_in_nbank.
// A pop-count reference model predicts every output each cycle; directed
// sections pin round-robin order, address wrap, credit pulses, clear and
// reset with hand-computed literals. Honors READ_B_IN_IDLE_FLUSH_EN.
module tb_read_b_in_nbank;

  localparam int NB  = 4;
  localparam int PB  = 16;
  localparam int NAB = 5;
  localparam int FSU = 4;
  localparam int IT  = 16;
  localparam int BA  = NAB - $clog2(NB);
  localparam int WW  = PB + 1;
  localparam int CW  = $clog2(FSU + 1);

  logic           clk = 1'b0;
  logic           reset_n;
  logic           clear;
  logic           ap_start;
  logic           ack;
  logic [NB*WW-1:0] doutb_flat;
  logic [NB*BA-1:0] addrb_flat;
  logic [NB-1:0]  web;
  logic [PB-1:0]  dout;
  logic           vld;
  logic           upd;
  logic [CW-1:0]  cnt;
  logic [WW-1:0]  bankWord [NB];

  int checks = 0;
  int errors = 0;

  // Reference model state, advanced once per cycle by compareModel.
  int   popTotal;
  int   bankPops [NB];
  int   consumed;
  int   idleRun;
  logic expUpd;
  int   expCnt;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NB; g++) begin : g_bus
    assign doutb_flat[g*WW +: WW] = bankWord[g];
  end

  read_b_in_nbank #(
    .NUM_BANKS(NB), .PAYLOAD_BITS(PB), .NUM_ADDR_BITS(NAB),
    .FREESPACE_UPDATE_SIZE(FSU), .IDLE_TIMEOUT(IT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .ap_start(ap_start),
    .ack_user2b_in(ack), .doutb_flat(doutb_flat), .addrb_flat(addrb_flat),
    .web(web), .dout_leaf_interface2user(dout), .vld_bram_in2user(vld),
    .freespace_update(upd), .freespace_cnt(cnt)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge; return at the falling edge.
  task automatic applyStimulus(input logic [NB-1:0] vmask, input logic ackIn,
                               input logic apIn, input logic clrIn);
    @(posedge clk);
    #1;
    for (int k = 0; k < NB; k++) bankWord[k] = {vmask[k], PB'($urandom)};
    ack      = ackIn;
    ap_start = apIn;
    clear    = clrIn;
    @(negedge clk);
  endtask

  task automatic popN(input int n);
    for (int i = 0; i < n; i++) applyStimulus('1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic clearCycle();
    applyStimulus('1, 1'b0, 1'b1, 1'b1);
  endtask

  // Predict all outputs from pop counts, compare, then advance the model.
  always @(negedge clk) begin : compareModel
    int ptr;
    logic mVld, mPop, nUpd;
    int nCnt;
    logic [PB-1:0] mDout;
    logic [NB-1:0] mWeb;
    logic [NB*BA-1:0] mAddr;
    if (!reset_n) begin
      popTotal = 0;
      for (int k = 0; k < NB; k++) bankPops[k] = 0;
      consumed = 0;
      idleRun  = 0;
      expUpd   = 1'b0;
      expCnt   = 0;
    end
    ptr   = popTotal % NB;
    mVld  = bankWord[ptr][PB] & ap_start;
    mDout = bankWord[ptr][PB-1:0];
    mPop  = mVld & ack;
    mWeb  = '0;
    if (mPop && !clear) mWeb[ptr] = 1'b1;
    for (int k = 0; k < NB; k++) mAddr[k*BA +: BA] = BA'(bankPops[k] % (1 << BA));
    checkOutput("model_vld", vld, mVld);
    checkOutput("model_dout", dout, mDout);
    checkOutput("model_web", web, mWeb);
    checkOutput("model_addrb", addrb_flat, mAddr);
    checkOutput("model_update", upd, expUpd);
    checkOutput("model_cnt", cnt, expCnt);
    if (reset_n) begin
      nUpd = 1'b0;
      nCnt = 0;
      if (clear) begin
        popTotal = 0;
        for (int k = 0; k < NB; k++) bankPops[k] = 0;
        consumed = 0;
        idleRun  = 0;
      end else if (mPop) begin
        popTotal++;
        bankPops[ptr]++;
        consumed++;
        idleRun = 0;
        if (consumed == FSU) begin
          nUpd = 1'b1;
          nCnt = FSU;
          consumed = 0;
        end
      end else begin
`ifdef READ_B_IN_IDLE_FLUSH_EN
        if (consumed > 0) begin
          idleRun++;
          if (idleRun == IT) begin
            nUpd = 1'b1;
            nCnt = consumed;
            consumed = 0;
            idleRun = 0;
          end
        end else begin
          idleRun = 0;
        end
`endif
      end
      expUpd = nUpd;
      expCnt = nCnt;
    end
  end

  initial begin
    int pulseIdx[$];
    int pulseCnt[$];
    int mode;
    logic [NB-1:0] vm;
    logic a, ap, cl;

    reset_n  = 1'b0;
    clear    = 1'b0;
    ap_start = 1'b0;
    ack      = 1'b0;
    for (int k = 0; k < NB; k++) bankWord[k] = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_addrb", addrb_flat, 0);
    checkOutput("reset_update", upd, 0);
    checkOutput("reset_cnt", cnt, 0);
    reset_n = 1'b1;

    // Round-robin over 4 banks, 8 pops, two full credit blocks.
    clearCycle();
    for (int i = 0; i < 10; i++) begin
      applyStimulus('1, (i < 8), 1'b1, 1'b0);
      if (i < 8) checkOutput($sformatf("rr_web_%0d", i), web, 1 << (i % 4));
      if (upd) begin
        pulseIdx.push_back(i);
        checkOutput("rr_pulse_cnt", cnt, 4);
      end
      if (i == 8) begin
        checkOutput("rr_addrb", addrb_flat, 12'h492);
        checkOutput("rr_dout_bank0", dout, bankWord[0][PB-1:0]);
      end
    end
    checkOutput("rr_pulse_count", pulseIdx.size(), 2);
    if (pulseIdx.size() == 2) begin
      checkOutput("rr_pulse_first", pulseIdx[0], 4);
      checkOutput("rr_pulse_second", pulseIdx[1], 8);
    end

    // Invalid bank 2 blocks the pop until its valid bit returns.
    clearCycle();
    popN(2);
    applyStimulus(4'b1011, 1'b1, 1'b1, 1'b0);
    checkOutput("inv_web", web, 0);
    checkOutput("inv_vld", vld, 0);
    applyStimulus('1, 1'b1, 1'b1, 1'b0);
    checkOutput("inv_addrb_hold", addrb_flat, 12'h009);
    checkOutput("inv_web_resume", web, 4'b0100);
    applyStimulus('1, 1'b0, 1'b1, 1'b0);
    checkOutput("inv_addrb_after", addrb_flat, 12'h049);

    // Each bank address wraps 7 -> 0 after 8 pops on it.
    clearCycle();
    popN(28);
    applyStimulus('1, 1'b0, 1'b1, 1'b0);
    checkOutput("wrap_addrb_7", addrb_flat, 12'hFFF);
    popN(4);
    applyStimulus('1, 1'b0, 1'b1, 1'b0);
    checkOutput("wrap_addrb_0", addrb_flat, 0);

    // Partial block followed by a long idle stretch.
    clearCycle();
    popN(3);
    pulseIdx.delete();
    pulseCnt.delete();
    for (int j = 0; j < 40; j++) begin
      applyStimulus('1, 1'b0, 1'b1, 1'b0);
      if (upd) begin
        pulseIdx.push_back(j);
        pulseCnt.push_back(int'(cnt));
      end
    end
`ifdef READ_B_IN_IDLE_FLUSH_EN
    checkOutput("idle_pulse_count", pulseIdx.size(), 1);
    if (pulseIdx.size() == 1) begin
      checkOutput("idle_cycles_before_flush", pulseIdx[0], IT);
      checkOutput("idle_flush_cnt", pulseCnt[0], 3);
    end
`else
    checkOutput("idle_no_pulse", pulseIdx.size(), 0);
`endif

    // A pop in the timeout cycle suppresses the flush.
    clearCycle();
    popN(1);
    for (int j = 0; j < IT - 1; j++) applyStimulus('1, 1'b0, 1'b1, 1'b0);
    popN(1);
    applyStimulus('1, 1'b0, 1'b1, 1'b0);
    checkOutput("timeout_pop_no_flush", upd, 0);
    for (int j = 0; j < 20; j++) applyStimulus('1, 1'b0, 1'b1, 1'b0);

    // Clear together with the pop that would complete a block.
    clearCycle();
    popN(3);
    applyStimulus('1, 1'b1, 1'b1, 1'b1);
    checkOutput("clear_web", web, 0);
    applyStimulus('1, 1'b0, 1'b1, 1'b0);
    checkOutput("clear_addrb", addrb_flat, 0);
    checkOutput("clear_no_pulse", upd, 0);
    checkOutput("clear_dout_bank0", dout, bankWord[0][PB-1:0]);

    // Randomized traffic in phases: streaming, sparse ack, idle, ap_start toggling.
    mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) mode = $urandom_range(0, 3);
      for (int k = 0; k < NB; k++) vm[k] = ($urandom_range(0, 7) != 0);
      case (mode)
        0: begin a = 1'b1; ap = 1'b1; end
        1: begin a = 1'($urandom_range(0, 1)); ap = 1'b1; end
        2: begin a = ($urandom_range(0, 31) == 0); ap = 1'b1; end
        default: begin a = 1'($urandom_range(0, 1)); ap = 1'($urandom_range(0, 1)); end
      endcase
      cl = ($urandom_range(0, 149) == 0);
      applyStimulus(vm, a, ap, cl);
    end

    // Asynchronous reset mid-stream returns registered outputs at once.
    popN(5);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_addrb", addrb_flat, 0);
    checkOutput("midreset_update", upd, 0);
    checkOutput("midreset_cnt", cnt, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    popN(6);
    repeat (3) applyStimulus('1, 1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
